uart_rx_ctrl: RTL and testbench

Read-side controller for the UART receive FIFO.
- Turns host RBR/LSR/FCR accesses into FIFO pop, reset and status-clear strobes.
- Computes the received-data-available (trigger-level) and character-timeout interrupt conditions.
- Sits between the register file and the receive FIFO; the receiver drives the FIFO push directly, and this block only observes that push.

---
 rtl/uart_rx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-FIFO read controller: turns host RBR/LSR/FCR accesses into FIFO strobes and raises RDA/timeout interrupts.
// Latency: pop one cycle after rbr_rd, FCR and LSR strobes one cycle after the access, interrupts one cycle after their condition.
// Backpressure: rbr_rd is dropped while a pop is settling (rbr_busy) or while the FIFO is empty.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_COUNTER_W = 5,
    parameter int TOUT_W         = 10
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      fcr_wr,
    input  logic                      fcr_fifo_en,
    input  logic                      fcr_rx_clr,
    input  logic [1:0]                fcr_trig,
    input  logic                      ier_rda,
    input  logic                      rbr_rd,
    input  logic                      lsr_rd,
    input  logic                      baud_tick,
    input  logic [TOUT_W-1:0]         tout_ticks,
    input  logic                      rx_push,
    input  logic [FIFO_COUNTER_W-1:0] rx_count,
    input  logic                      rx_error_bit,
    output logic                      fifo_pop,
    output logic                      fifo_reset,
    output logic                      reset_status,
    output logic                      rbr_busy,
    output logic                      data_ready,
    output logic                      lsr_err,
    output logic                      rda_int,
    output logic                      tout_int
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t                      state_q, state_d;
    logic                        fifo_en_q, fifo_en_d;
    logic [1:0]                  trig_q, trig_d;
    logic                        fifo_reset_q, fifo_reset_d;
    logic                        reset_status_q, reset_status_d;
    logic [TOUT_W-1:0]           tcnt_q, tcnt_d;
    logic                        tout_flag_q, tout_flag_d;
    logic                        rda_int_q, rda_int_d;
    logic                        tout_int_q, tout_int_d;
    logic [FIFO_COUNTER_W-1:0]   thr;
    logic                        fifo_empty;
    logic                        tout_restart;

    // Trigger levels saturate at the FIFO depth so small FIFOs can still interrupt.
    function automatic logic [FIFO_COUNTER_W-1:0] lvl(input int n);
        return (n > FIFO_DEPTH) ? FIFO_COUNTER_W'(FIFO_DEPTH) : FIFO_COUNTER_W'(n);
    endfunction

    always_comb begin
        thr = lvl(1);
        if (fifo_en_q) begin
            case (trig_q)
                2'b00:   thr = lvl(1);
                2'b01:   thr = lvl(4);
                2'b10:   thr = lvl(8);
                default: thr = lvl(14);
            endcase
        end
    end

    assign fifo_empty   = (rx_count == '0);
    assign tout_restart = rx_push | rbr_rd | fifo_reset_q | fifo_empty;

    always_comb begin
        fifo_en_d      = fifo_en_q;
        trig_d         = trig_q;
        fifo_reset_d   = 1'b0;
        reset_status_d = lsr_rd;
        if (fcr_wr) begin
            fifo_en_d    = fcr_fifo_en;
            trig_d       = fcr_trig;
            fifo_reset_d = fcr_rx_clr | (fcr_fifo_en != fifo_en_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rbr_rd && !fifo_empty) state_d = POP;
            POP:     state_d = SETTLE;
            default: state_d = IDLE;
        endcase
        if (fifo_reset_q) state_d = IDLE;
    end

    // Clear wins over set: a push or read in the expiry cycle keeps the flag low.
    always_comb begin
        tcnt_d      = tcnt_q;
        tout_flag_d = tout_flag_q;
        if (tout_restart) begin
            tcnt_d      = tout_ticks;
            tout_flag_d = 1'b0;
        end else begin
            if (baud_tick && (tcnt_q != '0)) tcnt_d = tcnt_q - TOUT_W'(1);
            if (tcnt_q == '0) tout_flag_d = 1'b1;
        end
    end

    assign rda_int_d  = ier_rda & (rx_count >= thr);
    assign tout_int_d = ier_rda & tout_flag_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            fifo_en_q      <= 1'b0;
            trig_q         <= 2'b00;
            fifo_reset_q   <= 1'b0;
            reset_status_q <= 1'b0;
            tcnt_q         <= '0;
            tout_flag_q    <= 1'b0;
            rda_int_q      <= 1'b0;
            tout_int_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fifo_en_q      <= fifo_en_d;
            trig_q         <= trig_d;
            fifo_reset_q   <= fifo_reset_d;
            reset_status_q <= reset_status_d;
            tcnt_q         <= tcnt_d;
            tout_flag_q    <= tout_flag_d;
            rda_int_q      <= rda_int_d;
            tout_int_q     <= tout_int_d;
        end
    end

    assign fifo_pop     = (state_q == POP);
    assign rbr_busy     = (state_q != IDLE);
    assign fifo_reset   = fifo_reset_q;
    assign reset_status = reset_status_q;
    assign data_ready   = !fifo_empty;
    assign lsr_err      = rx_error_bit & fifo_en_q;
    assign rda_int      = rda_int_q;
    assign tout_int     = tout_int_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle vector table plus hand-built pop, timeout and FIFO-clear sequences.
module tb_uart_rx_ctrl;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       fcr_wr = 1'b0, fcr_fifo_en = 1'b0, fcr_rx_clr = 1'b0;
    logic [1:0] fcr_trig = 2'b00;
    logic       ier_rda = 1'b0, rbr_rd = 1'b0, lsr_rd = 1'b0, baud_tick = 1'b0;
    logic [9:0] tout_ticks = 10'd100;
    logic       rx_push = 1'b0;
    logic [4:0] rx_count = 5'd0;
    logic       rx_error_bit = 1'b0;
    logic       fifo_pop, fifo_reset, reset_status, rbr_busy;
    logic       data_ready, lsr_err, rda_int, tout_int;

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(16), .FIFO_COUNTER_W(5), .TOUT_W(10)) dut (
        .clk(clk), .nreset(nreset),
        .fcr_wr(fcr_wr), .fcr_fifo_en(fcr_fifo_en), .fcr_rx_clr(fcr_rx_clr), .fcr_trig(fcr_trig),
        .ier_rda(ier_rda), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd), .baud_tick(baud_tick),
        .tout_ticks(tout_ticks), .rx_push(rx_push), .rx_count(rx_count), .rx_error_bit(rx_error_bit),
        .fifo_pop(fifo_pop), .fifo_reset(fifo_reset), .reset_status(reset_status), .rbr_busy(rbr_busy),
        .data_ready(data_ready), .lsr_err(lsr_err), .rda_int(rda_int), .tout_int(tout_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       wr, en, clr;
        bit [1:0] trig;
        bit       ier;
        bit [4:0] cnt;
        bit       err, lsr;
        bit       e_frst, e_rda, e_lerr, e_dr, e_rst;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input bit wr, input bit en, input bit clr, input bit [1:0] trig,
                                input bit ier, input bit [4:0] cnt, input bit err, input bit lsr,
                                input bit e_frst, input bit e_rda, input bit e_lerr,
                                input bit e_dr, input bit e_rst);
        vec_t v;
        v.wr = wr; v.en = en; v.clr = clr; v.trig = trig; v.ier = ier; v.cnt = cnt;
        v.err = err; v.lsr = lsr; v.e_frst = e_frst; v.e_rda = e_rda; v.e_lerr = e_lerr;
        v.e_dr = e_dr; v.e_rst = e_rst;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Registered outputs after each tick reflect that row's inputs; data_ready/lsr_err reflect the row held.
        tbl[0]  = mk(H, H, L, 2'b10, H, 5'd0,  L, L,  H, L, L, L, L);
        tbl[1]  = mk(L, H, L, 2'b10, H, 5'd7,  L, L,  L, L, L, H, L);
        tbl[2]  = mk(L, H, L, 2'b10, H, 5'd8,  L, L,  L, H, L, H, L);
        tbl[3]  = mk(L, H, L, 2'b10, H, 5'd8,  L, L,  L, H, L, H, L);
        tbl[4]  = mk(L, H, L, 2'b10, H, 5'd7,  L, L,  L, L, L, H, L);
        tbl[5]  = mk(L, H, L, 2'b10, H, 5'd7,  H, L,  L, L, H, H, L);
        tbl[6]  = mk(H, H, L, 2'b11, H, 5'd14, H, L,  L, H, H, H, L);
        tbl[7]  = mk(L, H, L, 2'b11, H, 5'd13, H, L,  L, L, H, H, L);
        tbl[8]  = mk(L, H, L, 2'b11, H, 5'd16, H, L,  L, H, H, H, L);
        tbl[9]  = mk(L, H, L, 2'b11, L, 5'd16, H, L,  L, L, H, H, L);
        tbl[10] = mk(L, H, L, 2'b11, H, 5'd1,  H, H,  L, L, H, H, H);
        tbl[11] = mk(L, H, L, 2'b11, H, 5'd1,  H, L,  L, L, H, H, L);
        tbl[12] = mk(H, L, L, 2'b00, H, 5'd1,  H, L,  H, L, L, H, L);
        tbl[13] = mk(L, L, L, 2'b00, H, 5'd1,  H, L,  L, H, L, H, L);
        tbl[14] = mk(H, L, H, 2'b00, H, 5'd0,  H, L,  H, L, L, L, L);
        tbl[15] = mk(L, L, L, 2'b00, H, 5'd0,  L, L,  L, L, L, L, L);

        // Reset, then idle with everything quiet.
        #12;
        chk("rst_rda", rda_int, 1'b0);
        chk("rst_busy", rbr_busy, 1'b0);
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outs", |{fifo_pop, fifo_reset, reset_status, rbr_busy,
                               data_ready, lsr_err, rda_int, tout_int}, 1'b0);
        end

        // Table: FCR config, trigger thresholds, status strobes.
        for (int i = 0; i < 16; i++) begin
            fcr_wr = tbl[i].wr; fcr_fifo_en = tbl[i].en; fcr_rx_clr = tbl[i].clr;
            fcr_trig = tbl[i].trig; ier_rda = tbl[i].ier; rx_count = tbl[i].cnt;
            rx_error_bit = tbl[i].err; lsr_rd = tbl[i].lsr;
            tick();
            chk($sformatf("tbl%0d_fifo_reset", i), fifo_reset, tbl[i].e_frst);
            chk($sformatf("tbl%0d_rda_int", i), rda_int, tbl[i].e_rda);
            chk($sformatf("tbl%0d_lsr_err", i), lsr_err, tbl[i].e_lerr);
            chk($sformatf("tbl%0d_data_ready", i), data_ready, tbl[i].e_dr);
            chk($sformatf("tbl%0d_reset_status", i), reset_status, tbl[i].e_rst);
            chk($sformatf("tbl%0d_fifo_pop", i), fifo_pop, 1'b0);
        end
        fcr_wr = 1'b0; fcr_rx_clr = 1'b0; lsr_rd = 1'b0; rx_error_bit = 1'b0; ier_rda = 1'b0;

        // Back-to-back reads: rbr_rd at N, N+1, N+3 -> pops at N+1, N+4.
        rx_count = 5'd3;
        tick();
        begin
            bit rd_pat[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            bit pop_pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            bit busy_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int k = 0; k < 6; k++) begin
                rbr_rd = rd_pat[k];
                tick();
                chk($sformatf("rd_pop_n%0d", k + 1), fifo_pop, pop_pat[k]);
                chk($sformatf("rd_busy_n%0d", k + 1), rbr_busy, busy_pat[k]);
            end
        end
        rbr_rd = 1'b0;

        // Read of an empty FIFO is dropped.
        rx_count = 5'd0;
        rbr_rd = 1'b1;
        tick();
        rbr_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("empty_pop", fifo_pop, 1'b0);
            chk("empty_busy", rbr_busy, 1'b0);
            tick();
        end

        // Character timeout: tout_ticks=5, push at P -> tout_int at P+8.
        tout_ticks = 10'd5;
        tick();
        ier_rda = 1'b1; baud_tick = 1'b1; rx_count = 5'd2; rx_push = 1'b1;
        tick();
        rx_push = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("tout_p%0d", k), tout_int, (k >= 8) ? 1'b1 : 1'b0);
            if (k < 9) tick();
        end
        rbr_rd = 1'b1;
        tick();
        rbr_rd = 1'b0;
        chk("tout_rd_r1", tout_int, 1'b1);
        tick();
        chk("tout_rd_r2", tout_int, 1'b0);

        // Let it time out again, then clear the FIFO through FCR.
        begin
            int n = 0;
            while (tout_int !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("tout_rearm", tout_int, 1'b1);
        end
        fcr_wr = 1'b1; fcr_rx_clr = 1'b1; fcr_fifo_en = 1'b0;
        tick();
        fcr_wr = 1'b0; fcr_rx_clr = 1'b0;
        chk("clr_frst_f1", fifo_reset, 1'b1);
        chk("clr_tout_f1", tout_int, 1'b1);
        tick();
        chk("clr_frst_f2", fifo_reset, 1'b0);
        chk("clr_tout_f2", tout_int, 1'b1);
        tick();
        chk("clr_tout_f3", tout_int, 1'b0);
        baud_tick = 1'b0;

        // FIFO clear requested while a pop is in flight.
        rx_count = 5'd3;
        tick();
        rbr_rd = 1'b1;
        tick();
        rbr_rd = 1'b0;
        chk("popclr_pop_a1", fifo_pop, 1'b1);
        fcr_wr = 1'b1; fcr_rx_clr = 1'b1;
        tick();
        fcr_wr = 1'b0; fcr_rx_clr = 1'b0;
        chk("popclr_frst_a2", fifo_reset, 1'b1);
        chk("popclr_pop_a2", fifo_pop, 1'b0);
        tick();
        chk("popclr_frst_a3", fifo_reset, 1'b0);
        chk("popclr_busy_a3", rbr_busy, 1'b0);
        tick();
        chk("popclr_tout_a4", tout_int, 1'b0);
        chk("popclr_busy_a4", rbr_busy, 1'b0);

        // LSR read -> single reset_status pulse.
        lsr_rd = 1'b1;
        tick();
        lsr_rd = 1'b0;
        chk("lsr_rst_n1", reset_status, 1'b1);
        tick();
        chk("lsr_rst_n2", reset_status, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
